// File: rtl/fu_mem_stage_reg_pkg.sv
// Shared types and encodings for the MEM-stage pipeline register.
// FSM states, memory-op codes, load funct3 codes and access-legality helpers.
package b8_mem_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} mem_state_e;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // 111 has no encoding; LD/LWU only exist when the datapath is 64 bits wide.
    function automatic logic f3_illegal(input logic [2:0] f3, input int xlen);
        return (f3 == 3'b111) || ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)));
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [2:0] low);
        case (f3[1:0])
            2'b01:   return low[0];
            2'b10:   return |low[1:0];
            2'b11:   return |low;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fu_mem_stage_reg_if.sv
// EX-side, RAM-side and WB-side signals of the MEM stage bundled in one interface.
// FU_MEM_DEBUG_EN adds the instruction word/address debug pass-through signals.
interface fu_mem_stage_reg_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5,
    parameter int PID_W  = 2
);
    localparam int MASK_W = XLEN / 8;

    logic              in_valid;
    logic              in_ready;
    logic              in_rd_we;
    logic [RD_W-1:0]   in_rd_addr;
    logic [XLEN-1:0]   in_rd_data;
    logic [PID_W-1:0]  in_pid;
    logic [2:0]        in_funct3;
    logic [1:0]        in_mem_op;
    logic [ADDR_W-1:0] in_addr;
    logic [XLEN-1:0]   in_wdata;
    logic [MASK_W-1:0] in_wmask;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [MASK_W-1:0] mem_req_mask;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;

    logic              out_valid;
    logic              out_ready;
    logic              out_rd_we;
    logic [RD_W-1:0]   out_rd_addr;
    logic [XLEN-1:0]   out_rd_data;
    logic [PID_W-1:0]  out_pid;
    logic              out_misalign;
`ifdef FU_MEM_DEBUG_EN
    logic [31:0]       inst_i;
    logic [31:0]       instAddr_i;
    logic [31:0]       inst_o;
    logic [31:0]       instAddr_o;
`endif

    // All transfers are valid/ready: a beat moves on a clock edge where both are high,
    // and the sender holds its payload stable while valid is high and ready is low.
    modport slave (
        input  in_valid, in_rd_we, in_rd_addr, in_rd_data, in_pid, in_funct3,
               in_mem_op, in_addr, in_wdata, in_wmask,
               mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_mask, out_valid, out_rd_we, out_rd_addr, out_rd_data,
               out_pid, out_misalign
`ifdef FU_MEM_DEBUG_EN
        , input inst_i, instAddr_i
        , output inst_o, instAddr_o
`endif
    );

    modport master (
        output in_valid, in_rd_we, in_rd_addr, in_rd_data, in_pid, in_funct3,
               in_mem_op, in_addr, in_wdata, in_wmask,
               mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
        input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_mask, out_valid, out_rd_we, out_rd_addr, out_rd_data,
               out_pid, out_misalign
`ifdef FU_MEM_DEBUG_EN
        , output inst_i, instAddr_i
        , input inst_o, instAddr_o
`endif
    );

endinterface

// File: rtl/fu_mem_stage_reg_load_align.sv
// Combinational load formatter: selects the addressed byte lane of the raw RAM word
// and sign/zero-extends it according to funct3; flags funct3 codes illegal for XLEN.
module fu_load_align
    import b8_mem_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  raw,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data,
    output logic             illegal
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        data    = shifted;
        case (funct3)
            F3_LB:   data = XLEN'($signed(shifted[7:0]));
            F3_LH:   data = XLEN'($signed(shifted[15:0]));
            F3_LW:   data = XLEN'($signed(shifted[31:0]));
            F3_LBU:  data = XLEN'(shifted[7:0]);
            F3_LHU:  data = XLEN'(shifted[15:0]);
            F3_LWU:  data = XLEN'(shifted[31:0]);
            default: data = shifted;
        endcase
        illegal = f3_illegal(funct3, XLEN);
    end

endmodule

// File: rtl/fu_mem_stage_reg.sv
// MEM-stage pipeline register for one FU way: 1-cycle pass-through for ALU ops and a
// blocking RAM request/response for loads/stores. FU_MEM_DEBUG_EN adds inst/instAddr.
module fu_mem_stage_reg
    import b8_mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5,
    parameter int PID_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    fu_mem_stage_reg_if.slave  bus,
    output mem_state_e         fsm_state
);
    localparam int OFF_W = $clog2(XLEN / 8);

    mem_state_e        state;
    logic              accept;
    logic              is_mem;
    logic              misalign;
    logic              f3_bad;
    logic [OFF_W-1:0]  align_off;
    logic [2:0]        align_f3;
    logic [XLEN-1:0]   load_data;

    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic              rd_we_q;
    logic [RD_W-1:0]   rd_addr_q;
    logic [PID_W-1:0]  pid_q;
    logic [XLEN-1:0]   rd_data_q;
`ifdef FU_MEM_DEBUG_EN
    logic [31:0]       inst_q;
    logic [31:0]       inst_addr_q;
`endif

    assign fsm_state    = state;
    assign bus.in_ready = !reset && (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mem       = (bus.in_mem_op == MEM_OP_LOAD) || (bus.in_mem_op == MEM_OP_STORE);

    // The formatter checks the incoming funct3 while idle and formats the latched access otherwise.
    assign align_off = (state == IDLE) ? bus.in_addr[OFF_W-1:0] : off_q;
    assign align_f3  = (state == IDLE) ? bus.in_funct3 : f3_q;
    assign misalign  = f3_bad || addr_misaligned(bus.in_funct3, bus.in_addr[2:0]);

    fu_load_align #(.XLEN(XLEN)) u_align (
        .raw     (bus.mem_resp_data),
        .offset  (align_off),
        .funct3  (align_f3),
        .data    (load_data),
        .illegal (f3_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_we    <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_req_wdata <= '0;
            bus.mem_req_mask  <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_rd_we     <= 1'b0;
            bus.out_rd_addr   <= '0;
            bus.out_rd_data   <= '0;
            bus.out_pid       <= '0;
            bus.out_misalign  <= 1'b0;
            f3_q              <= '0;
            off_q             <= '0;
            rd_we_q           <= 1'b0;
            rd_addr_q         <= '0;
            pid_q             <= '0;
            rd_data_q         <= '0;
`ifdef FU_MEM_DEBUG_EN
            inst_q            <= '0;
            inst_addr_q       <= '0;
            bus.inst_o        <= '0;
            bus.instAddr_o    <= '0;
`endif
        end else begin
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mem && !misalign) begin
                        state             <= REQ;
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_req_we    <= (bus.in_mem_op == MEM_OP_STORE);
                        bus.mem_req_addr  <= {bus.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus.mem_req_wdata <= bus.in_wdata;
                        bus.mem_req_mask  <= (bus.in_mem_op == MEM_OP_STORE) ? bus.in_wmask : '0;
                        f3_q              <= bus.in_funct3;
                        off_q             <= bus.in_addr[OFF_W-1:0];
                        rd_we_q           <= bus.in_rd_we;
                        rd_addr_q         <= bus.in_rd_addr;
                        pid_q             <= bus.in_pid;
                        rd_data_q         <= bus.in_rd_data;
`ifdef FU_MEM_DEBUG_EN
                        inst_q            <= bus.inst_i;
                        inst_addr_q       <= bus.instAddr_i;
`endif
                    end else if (accept) begin
                        // ALU op, or a faulting access that never reaches the RAM.
                        bus.out_valid    <= 1'b1;
                        bus.out_rd_we    <= bus.in_rd_we && !is_mem;
                        bus.out_rd_addr  <= bus.in_rd_addr;
                        bus.out_rd_data  <= bus.in_rd_data;
                        bus.out_pid      <= bus.in_pid;
                        bus.out_misalign <= is_mem;
`ifdef FU_MEM_DEBUG_EN
                        bus.inst_o       <= bus.inst_i;
                        bus.instAddr_o   <= bus.instAddr_i;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        bus.out_valid    <= 1'b1;
                        bus.out_rd_we    <= rd_we_q && !bus.mem_req_we;
                        bus.out_rd_addr  <= rd_addr_q;
                        bus.out_rd_data  <= bus.mem_req_we ? rd_data_q : load_data;
                        bus.out_pid      <= pid_q;
                        bus.out_misalign <= 1'b0;
`ifdef FU_MEM_DEBUG_EN
                        bus.inst_o       <= inst_q;
                        bus.instAddr_o   <= inst_addr_q;
`endif
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_mem_stage_reg.sv
// Directed bench for fu_mem_stage_reg (XLEN=64): ALU streaming, load formatting,
// stalled store, misaligned access, WB back-pressure and reset mid-transaction.
module tb_fu_mem_stage_reg;
    import b8_mem_pkg::*;

    logic       clk;
    logic       reset;
    mem_state_e fsm_state;
    int         n_checks;
    int         n_errors;
    logic [63:0] exp_q[$];

    fu_mem_stage_reg_if #(.XLEN(64), .ADDR_W(32), .RD_W(5), .PID_W(2)) bus ();

    fu_mem_stage_reg #(.XLEN(64), .ADDR_W(32), .RD_W(5), .PID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_rd_we   = 1'b0;
        bus.in_rd_addr = '0;
        bus.in_rd_data = '0;
        bus.in_pid     = '0;
        bus.in_funct3  = '0;
        bus.in_mem_op  = MEM_OP_NONE;
        bus.in_addr    = '0;
        bus.in_wdata   = '0;
        bus.in_wmask   = '0;
`ifdef FU_MEM_DEBUG_EN
        bus.inst_i     = '0;
        bus.instAddr_i = '0;
`endif
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] rd_data, input logic [4:0] rd_addr,
                            input logic [63:0] wdata, input logic [7:0] wmask);
        bus.in_valid   = 1'b1;
        bus.in_rd_we   = 1'b1;
        bus.in_rd_addr = rd_addr;
        bus.in_rd_data = rd_data;
        bus.in_pid     = 2'd2;
        bus.in_funct3  = f3;
        bus.in_mem_op  = op;
        bus.in_addr    = addr;
        bus.in_wdata   = wdata;
        bus.in_wmask   = wmask;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] resp, input logic [63:0] exp);
        drive_op(MEM_OP_LOAD, f3, addr, 64'h0, 5'd9, 64'h0, 8'h00);
        step();
        bus.in_valid = 1'b0;
        check_val({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
        check_val({tag, "_req_addr"}, 64'(bus.mem_req_addr), 64'({addr[31:3], 3'b000}));
        check_val({tag, "_req_we"}, 64'(bus.mem_req_we), 64'd0);
        check_val({tag, "_req_mask"}, 64'(bus.mem_req_mask), 64'd0);
        step();
        check_val({tag, "_req_drop"}, 64'(bus.mem_req_valid), 64'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = resp;
        step();
        bus.mem_resp_valid = 1'b0;
        check_val({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check_val({tag, "_data"}, bus.out_rd_data, exp);
        check_val({tag, "_rd_we"}, 64'(bus.out_rd_we), 64'd1);
        check_val({tag, "_misalign"}, 64'(bus.out_misalign), 64'd0);
        step();
        check_val({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.out_ready      = 1'b1;
        reset = 1'b1;
        step();
        step();

        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("rst_rd_data", bus.out_rd_data, 64'd0);
        check_val("rst_state", 64'(fsm_state), 64'(IDLE));
        reset = 1'b0;
        #1;
        check_val("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            drive_op(MEM_OP_NONE, 3'b000, 32'h0, 64'h1111 * (i + 1), 5'(i + 1), 64'h0, 8'h00);
            exp_q.push_back(64'h1111 * (i + 1));
            #1;
            check_val("alu_in_ready", 64'(bus.in_ready), 64'd1);
            step();
            check_val("alu_out_valid", 64'(bus.out_valid), 64'd1);
            check_val("alu_data", bus.out_rd_data, exp_q.pop_front());
            check_val("alu_rd_addr", 64'(bus.out_rd_addr), 64'(i + 1));
        end
        bus.in_valid = 1'b0;
        step();
        check_val("alu_drain", 64'(bus.out_valid), 64'd0);

        run_load("lb", F3_LB, 32'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lhu", F3_LHU, 32'h1002, 64'h1234_5678_BEEF_9ABC, 64'h0000_0000_0000_BEEF);
        run_load("lw", F3_LW, 32'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        run_load("lwu", F3_LWU, 32'h1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        run_load("ld", F3_LD, 32'h1008, 64'h8765_4321_0BAD_F00D, 64'h8765_4321_0BAD_F00D);

        // store stalled by the RAM for three cycles; stray response during REQ is ignored
        drive_op(MEM_OP_STORE, 3'b011, 32'h2008, 64'h0, 5'd7, 64'hCAFE_F00D_1234_5678, 8'hFF);
        step();
        bus.in_valid       = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_val("st_req_valid", 64'(bus.mem_req_valid), 64'd1);
            check_val("st_req_addr", 64'(bus.mem_req_addr), 64'h2008);
            check_val("st_req_wdata", bus.mem_req_wdata, 64'hCAFE_F00D_1234_5678);
            check_val("st_req_mask", 64'(bus.mem_req_mask), 64'hFF);
            check_val("st_req_we", 64'(bus.mem_req_we), 64'd1);
            check_val("st_in_ready", 64'(bus.in_ready), 64'd0);
            check_val("st_no_out", 64'(bus.out_valid), 64'd0);
            step();
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        check_val("st_req_held", 64'(bus.mem_req_valid), 64'd1);
        step();
        check_val("st_req_drop", 64'(bus.mem_req_valid), 64'd0);
        check_val("st_wait_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        check_val("st_wait2_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("st_wait2_out", 64'(bus.out_valid), 64'd0);
        bus.mem_resp_valid = 1'b1;
        step();
        bus.mem_resp_valid = 1'b0;
        check_val("st_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("st_rd_we", 64'(bus.out_rd_we), 64'd0);
        check_val("st_rd_addr", 64'(bus.out_rd_addr), 64'd7);
        check_val("st_in_ready", 64'(bus.in_ready), 64'd1);
        step();

        // misaligned LW never reaches the RAM
        drive_op(MEM_OP_LOAD, F3_LW, 32'h1002, 64'h0, 5'd3, 64'h0, 8'h00);
        step();
        bus.in_valid = 1'b0;
        check_val("mis_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("mis_flag", 64'(bus.out_misalign), 64'd1);
        check_val("mis_rd_we", 64'(bus.out_rd_we), 64'd0);
        check_val("mis_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check_val("mis_state", 64'(fsm_state), 64'(IDLE));
        step();
        check_val("mis_req_valid2", 64'(bus.mem_req_valid), 64'd0);

        // WB back-pressure: held output must not be overwritten
        bus.out_ready = 1'b0;
        drive_op(MEM_OP_NONE, 3'b000, 32'h0, 64'h55, 5'd11, 64'h0, 8'h00);
        step();
        drive_op(MEM_OP_NONE, 3'b000, 32'h0, 64'h66, 5'd12, 64'h0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            check_val("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check_val("bp_data", bus.out_rd_data, 64'h55);
            check_val("bp_rd_addr", 64'(bus.out_rd_addr), 64'd11);
            check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check_val("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check_val("bp_next_data", bus.out_rd_data, 64'h66);
        step();
        check_val("bp_drain", 64'(bus.out_valid), 64'd0);

        // reset while waiting for the RAM; the late response must be dropped
        drive_op(MEM_OP_LOAD, F3_LD, 32'h3000, 64'h0, 5'd4, 64'h0, 8'h00);
        step();
        bus.in_valid = 1'b0;
        step();
        check_val("rw_state", 64'(fsm_state), 64'(WAIT));
        reset = 1'b1;
        step();
        check_val("rw_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rw_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check_val("rw_req_addr", 64'(bus.mem_req_addr), 64'd0);
        check_val("rw_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("rw_state_idle", 64'(fsm_state), 64'(IDLE));
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        bus.mem_resp_valid = 1'b0;
        check_val("rw_late_resp", 64'(bus.out_valid), 64'd0);
        check_val("rw_late_data", bus.out_rd_data, 64'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
